// File: rtl/mio_arbiter.sv
// mio_arbiter: round-robin arbiter that grants one of NCH channels a single
// memory/IO access, drives the shared bus for the whole access and returns a
// one-cycle done pulse (plus err on timeout) to the granted channel.
module mio_arbiter #(
    parameter int NCH = 2,
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int TMO = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    we,
    input  logic [NCH*AW-1:0] addr,
    input  logic [NCH*DW-1:0] wdata,
    output logic [NCH-1:0]    done,
    output logic              err,
    output logic [DW-1:0]     rdata,
    output logic [AW-1:0]     bus_addr,
    output logic [DW-1:0]     bus_wdata,
    output logic              bus_cs,
    output logic              mem_w,
    input  logic [DW-1:0]     bus_rdata,
    input  logic              MIO_ready,
    output logic              busy
);

    localparam int          IW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [7:0]  TMO8 = TMO[7:0];

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] last_g;      // last granted channel; also the current winner once granted
    logic          we_l;
    logic          err_q;
    logic [7:0]    tmo_cnt;
    logic          win_found;
    logic [IW-1:0] win_idx;

    // Round-robin search starting just after the last granted channel, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NCH; k++) begin
            int j;
            j = (int'(last_g) + k) % NCH;
            if (!win_found && req[j]) begin
                win_found = 1'b1;
                win_idx   = IW'(j);
            end
        end
    end

    // IDLE -> ACCESS -> DONE -> IDLE; grant latches channel request, access waits
    // for MIO_ready or the timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last_g    <= IW'(NCH-1);
            we_l      <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rdata     <= '0;
            err_q     <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state     <= ACCESS;
                        last_g    <= win_idx;
                        we_l      <= we[win_idx];
                        bus_addr  <= addr[win_idx*AW +: AW];
                        bus_wdata <= wdata[win_idx*DW +: DW];
                        err_q     <= 1'b0;
                        tmo_cnt   <= '0;
                    end
                end
                ACCESS: begin
                    if (MIO_ready) begin
                        rdata   <= bus_rdata;
                        tmo_cnt <= '0;
                        state   <= DONE;
                    end else if (TMO8 != 8'd0 && tmo_cnt + 8'd1 == TMO8) begin
                        // Timed out: report err with zeroed read data.
                        err_q   <= 1'b1;
                        rdata   <= '0;
                        tmo_cnt <= '0;
                        state   <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Bus strobes and completion are decoded from state, so an async reset
    // drops bus_cs immediately and suppresses done for an aborted access.
    always_comb begin
        bus_cs = (state == ACCESS);
        mem_w  = bus_cs & we_l;
        busy   = (state != IDLE);
        err    = err_q & (state == DONE);
        done   = '0;
        if (state == DONE) done[last_g] = 1'b1;
    end

endmodule

// File: tb/tb_mio_arbiter.sv
// Directed bench: dut_a (NCH=2, TMO=4) covers basic read, timeout, request
// withdrawal and mid-access reset; dut_b (NCH=4, timeout disabled) covers
// round-robin order/period and a stalled write with late address changes.
module tb_mio_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // dut_a signals
    logic [1:0]  a_req, a_we, a_done;
    logic [63:0] a_addr, a_wdata;
    logic [31:0] a_rdata, a_baddr, a_bwdata, a_brdata;
    logic        a_err, a_cs, a_mw, a_rdy, a_busy;

    // dut_b signals
    logic [3:0]   b_req, b_we, b_done;
    logic [127:0] b_addr, b_wdata;
    logic [31:0]  b_rdata, b_baddr, b_bwdata, b_brdata;
    logic         b_err, b_cs, b_mw, b_rdy, b_busy;

    mio_arbiter #(.NCH(2), .AW(32), .DW(32), .TMO(4)) dut_a (
        .clk(clk), .reset(rst_n), .req(a_req), .we(a_we), .addr(a_addr),
        .wdata(a_wdata), .done(a_done), .err(a_err), .rdata(a_rdata),
        .bus_addr(a_baddr), .bus_wdata(a_bwdata), .bus_cs(a_cs), .mem_w(a_mw),
        .bus_rdata(a_brdata), .MIO_ready(a_rdy), .busy(a_busy)
    );

    mio_arbiter #(.NCH(4), .AW(32), .DW(32), .TMO(0)) dut_b (
        .clk(clk), .reset(rst_n), .req(b_req), .we(b_we), .addr(b_addr),
        .wdata(b_wdata), .done(b_done), .err(b_err), .rdata(b_rdata),
        .bus_addr(b_baddr), .bus_wdata(b_bwdata), .bus_cs(b_cs), .mem_w(b_mw),
        .bus_rdata(b_brdata), .MIO_ready(b_rdy), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        int ncs, n, prev;

        rst_n = 1'b0;
        a_req = '0; a_we = '0; a_rdy = 1'b0; a_brdata = '0;
        a_addr = {32'h300, 32'h100}; a_wdata = {32'hA1, 32'hA0};
        b_req = '0; b_we = '0; b_rdy = 1'b0; b_brdata = 32'hCAFE0000;
        b_addr = {32'h1003, 32'h1002, 32'h1001, 32'h1000}; b_wdata = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_cs_a", a_cs, 0);   chk("rst_busy_a", a_busy, 0);
        chk("rst_done_a", a_done, 0); chk("rst_rdata_a", a_rdata, 0);
        chk("rst_baddr_a", a_baddr, 0); chk("rst_busy_b", b_busy, 0);
        chk("rst_mw_b", b_mw, 0);   chk("rst_err_b", b_err, 0);
        rst_n = 1'b1;

        // basic read on ch0, 3-cycle latency
        @(negedge clk);
        a_req = 2'b01; a_brdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("rd_cs", a_cs, 1); chk("rd_baddr", a_baddr, 32'h100);
        chk("rd_mw", a_mw, 0); chk("rd_done_early", a_done, 0);
        a_rdy = 1'b1;
        @(negedge clk);
        chk("rd_done", a_done, 2'b01); chk("rd_rdata", a_rdata, 32'hDEADBEEF);
        chk("rd_err", a_err, 0); chk("rd_cs_off", a_cs, 0);
        a_req = '0; a_rdy = 1'b0;
        @(negedge clk);
        chk("rd_idle", a_busy, 0); chk("rd_done_1cyc", a_done, 0);

        // timeout with TMO=4
        a_req = 2'b01; a_brdata = 32'h55;
        ncs = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (a_done != 0) break;
            if (a_cs) ncs++;
        end
        chk("to_cycles", ncs, 4); chk("to_done", a_done, 2'b01);
        chk("to_err", a_err, 1); chk("to_rdata", a_rdata, 0);
        // req not sampled in DONE; MIO_ready outside ACCESS ignored
        a_req = 2'b10; a_rdy = 1'b1;
        @(negedge clk);
        chk("to_idle", a_busy, 0); chk("to_err_clr", a_err, 0);
        @(negedge clk);
        chk("to_next_cs", a_cs, 1); chk("to_next_addr", a_baddr, 32'h300);
        @(negedge clk);
        chk("to_next_done", a_done, 2'b10); chk("to_next_rdata", a_rdata, 32'h55);
        chk("to_next_err", a_err, 0);
        a_req = '0; a_rdy = 1'b0;

        // req withdrawn in first ACCESS cycle
        @(negedge clk);
        a_req = 2'b01;
        @(negedge clk);
        chk("wd_cs", a_cs, 1);
        a_req = '0;
        @(negedge clk);
        a_rdy = 1'b1;
        @(negedge clk);
        chk("wd_done", a_done, 2'b01);
        a_rdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("wd_no_regrant", a_busy, 0);

        // reset during 2nd ACCESS cycle
        a_req = 2'b10; a_brdata = 32'h77;
        @(negedge clk);
        chk("ar_cs", a_cs, 1); chk("ar_addr", a_baddr, 32'h300);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("ar_cs_async", a_cs, 0);
        chk("ar_busy_async", a_busy, 0);
        @(negedge clk);
        chk("ar_no_done", a_done, 0);
        rst_n = 1'b1; a_req = 2'b11; a_rdy = 1'b1;
        @(negedge clk);
        chk("ar_regrant_addr", a_baddr, 32'h100);
        @(negedge clk);
        chk("ar_regrant_done", a_done, 2'b01); chk("ar_rdata", a_rdata, 32'h77);
        a_req = '0; a_rdy = 1'b0;
        @(negedge clk);

        // round robin, NCH=4, all requesting, ready tied high
        b_req = 4'hF; b_rdy = 1'b1;
        n = 0; prev = 0;
        for (int c = 0; c < 16 && n < 5; c++) begin
            @(negedge clk);
            if (b_done != 0) begin
                chk("rr_order", b_done, 4'b0001 << (n % 4));
                chk("rr_addr", b_baddr, 32'h1000 + (n % 4));
                if (n > 0) chk("rr_period", c - prev, 3);
                prev = c;
                n++;
            end
        end
        chk("rr_count", n, 5);
        b_req = '0; b_rdy = 1'b0;
        @(negedge clk);

        // stalled write on ch1, late input changes must not leak onto the bus
        b_req = 4'b0010; b_we = 4'b0010;
        b_addr[63:32] = 32'h200; b_wdata[63:32] = 32'h12345678;
        ncs = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (b_cs && b_mw && b_baddr == 32'h200 && b_bwdata == 32'h12345678) ncs++;
            if (c == 0) begin
                b_addr[63:32] = 32'hBAD; b_wdata[63:32] = 32'h0; b_we = '0;
            end
            if (c == 5) b_rdy = 1'b1;
        end
        chk("wr_stable", ncs, 6);
        @(negedge clk);
        chk("wr_done", b_done, 4'b0010); chk("wr_err", b_err, 0);
        chk("wr_cs_off", b_cs, 0); chk("wr_mw_off", b_mw, 0);
        b_req = '0; b_rdy = 1'b0;
        @(negedge clk);
        chk("wr_idle", b_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
